// File: rtl/ascon_decrypt_ctrl.sv
// Ascon-128 receive-side controller: owns the 320-bit state, sequences the shared
// permutation core, releases plaintext and checks the received tag.
//
// state  | meaning
// IDLE   | waiting for start_i
// INIT_P | initial p12, then key XOR into S[3..4]
// AD_W   | waiting for an associated-data block
// AD_P   | p6 after an AD block
// CT_W   | waiting for a ciphertext block
// CT_P   | p6 between ciphertext blocks
// FIN    | padding + key XOR, then p12
// CMP    | tag compare result presented, done_o high
module ascon_decrypt_ctrl #(
    parameter int NB_AD = 1,
    parameter int NB_CT = 4
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [127:0] tag_i,
    input  logic [63:0]  ad_i,
    input  logic         ad_valid_i,
    output logic         ad_ready_o,
    input  logic [63:0]  cipher_i,
    input  logic         cipher_valid_i,
    output logic         cipher_ready_o,
    output logic [63:0]  plain_o,
    output logic         plain_valid_o,
    output logic         perm_start_o,
    output logic [3:0]   perm_rounds_o,
    output logic [319:0] perm_state_o,
    input  logic [319:0] perm_state_i,
    input  logic         perm_done_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         tag_ok_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT_P, S_AD_W, S_AD_P, S_CT_W, S_CT_P, S_FIN, S_CMP
    } state_t;

    localparam logic [63:0] IV      = 64'h80400c0600000000;
    localparam logic [63:0] PAD     = 64'h8000000000000000;
    localparam logic [3:0]  AD_LAST = 4'(NB_AD - 1);
    localparam logic [3:0]  CT_LAST = 4'(NB_CT - 1);

    state_t         r_fsm;
    state_t         w_fsm_nxt;
    logic [319:0]   r_s;
    logic [127:0]   r_key;
    logic [127:0]   r_tag;
    logic [3:0]     r_cnt;
    logic           r_pend;
    logic           r_perm_start;
    logic [3:0]     r_rounds;
    logic [63:0]    r_plain;
    logic           r_plain_valid;
    logic           r_ad_ready;
    logic           r_ct_ready;
    logic           r_busy;
    logic           r_done;
    logic           r_tag_ok;

    logic           w_perm_st;
    logic           w_issue;
    logic           w_pdone;
    logic           w_ad_xfer;
    logic           w_ct_xfer;

    assign w_perm_st = (r_fsm == S_INIT_P) || (r_fsm == S_AD_P) ||
                       (r_fsm == S_CT_P)   || (r_fsm == S_FIN);
    assign w_issue   = w_perm_st && !r_pend;
    // A done pulse only counts once our own request is out and the start pulse is over.
    assign w_pdone   = w_perm_st && r_pend && !r_perm_start && perm_done_i;
    assign w_ad_xfer = r_ad_ready && ad_valid_i;
    assign w_ct_xfer = r_ct_ready && cipher_valid_i;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:   if (start_i)   w_fsm_nxt = S_INIT_P;
            S_INIT_P: if (w_pdone)   w_fsm_nxt = S_AD_W;
            S_AD_W:   if (w_ad_xfer) w_fsm_nxt = S_AD_P;
            S_AD_P:   if (w_pdone)   w_fsm_nxt = (r_cnt < AD_LAST) ? S_AD_W : S_CT_W;
            S_CT_W:   if (w_ct_xfer) w_fsm_nxt = (r_cnt < CT_LAST) ? S_CT_P : S_FIN;
            S_CT_P:   if (w_pdone)   w_fsm_nxt = S_CT_W;
            S_FIN:    if (w_pdone)   w_fsm_nxt = S_CMP;
            S_CMP:                   w_fsm_nxt = S_IDLE;
            default:                 w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_s           <= '0;
            r_key         <= '0;
            r_tag         <= '0;
            r_cnt         <= '0;
            r_pend        <= 1'b0;
            r_perm_start  <= 1'b0;
            r_rounds      <= '0;
            r_plain       <= '0;
            r_plain_valid <= 1'b0;
            r_ad_ready    <= 1'b0;
            r_ct_ready    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tag_ok      <= 1'b0;
        end else begin
            r_perm_start  <= w_issue;
            r_plain_valid <= w_ct_xfer;
            r_ad_ready    <= (w_fsm_nxt == S_AD_W);
            r_ct_ready    <= (w_fsm_nxt == S_CT_W);
            r_busy        <= (w_fsm_nxt != S_IDLE);
            r_done        <= (w_fsm_nxt == S_CMP);
            if (w_issue) begin
                r_pend   <= 1'b1;
                r_rounds <= ((r_fsm == S_INIT_P) || (r_fsm == S_FIN)) ? 4'd12 : 4'd6;
            end else if (w_pdone) begin
                r_pend <= 1'b0;
            end
            case (r_fsm)
                S_IDLE: begin
                    if (start_i) begin
                        r_s      <= {IV, key_i, nonce_i};
                        r_key    <= key_i;
                        r_tag    <= tag_i;
                        r_cnt    <= '0;
                        r_tag_ok <= 1'b0;
                    end
                end
                S_INIT_P: if (w_pdone) r_s <= perm_state_i ^ {192'd0, r_key};
                S_AD_W:   if (w_ad_xfer) r_s[319:256] <= r_s[319:256] ^ ad_i;
                S_AD_P: begin
                    if (w_pdone) begin
                        if (r_cnt < AD_LAST) begin
                            r_s   <= perm_state_i;
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            r_s   <= perm_state_i ^ 320'd1;
                            r_cnt <= '0;
                        end
                    end
                end
                S_CT_W: begin
                    if (w_ct_xfer) begin
                        r_plain      <= r_s[319:256] ^ cipher_i;
                        r_s[319:256] <= cipher_i;
                    end
                end
                S_CT_P: begin
                    if (w_pdone) begin
                        r_s   <= perm_state_i;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_FIN: begin
                    // Padding and key are folded in on the same edge the request goes out.
                    if (w_issue) begin
                        r_s <= r_s ^ {PAD, r_key, 128'd0};
                    end else if (w_pdone) begin
                        r_s      <= perm_state_i;
                        r_tag_ok <= ((perm_state_i[127:0] ^ r_key) == r_tag);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ad_ready_o     = r_ad_ready;
    assign cipher_ready_o = r_ct_ready;
    assign plain_o        = r_plain;
    assign plain_valid_o  = r_plain_valid;
    assign perm_start_o   = r_perm_start;
    assign perm_rounds_o  = r_rounds;
    assign perm_state_o   = r_s;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign tag_ok_o       = r_tag_ok;

endmodule

// File: tb/tb_ascon_decrypt_ctrl.sv
// Directed bench for ascon_decrypt_ctrl: Ascon permutation responder, golden encryptor,
// table of message scenarios plus reset/abort sequences.
module tb_ascon_decrypt_ctrl;
    logic         clock_i = 1'b0;
    logic         resetb_i = 1'b0;
    logic         start_i = 1'b0;
    logic [127:0] key_i = '0;
    logic [127:0] nonce_i = '0;
    logic [127:0] tag_i = '0;
    logic [63:0]  ad_i = '0;
    logic         ad_valid_i = 1'b0;
    logic         ad_ready_o;
    logic [63:0]  cipher_i = '0;
    logic         cipher_valid_i = 1'b0;
    logic         cipher_ready_o;
    logic [63:0]  plain_o;
    logic         plain_valid_o;
    logic         perm_start_o;
    logic [3:0]   perm_rounds_o;
    logic [319:0] perm_state_o;
    logic [319:0] perm_state_i = '0;
    logic         perm_done_i = 1'b0;
    logic         busy_o;
    logic         done_o;
    logic         tag_ok_o;

    ascon_decrypt_ctrl #(.NB_AD(1), .NB_CT(4)) dut (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i),
        .key_i(key_i), .nonce_i(nonce_i), .tag_i(tag_i),
        .ad_i(ad_i), .ad_valid_i(ad_valid_i), .ad_ready_o(ad_ready_o),
        .cipher_i(cipher_i), .cipher_valid_i(cipher_valid_i), .cipher_ready_o(cipher_ready_o),
        .plain_o(plain_o), .plain_valid_o(plain_valid_o),
        .perm_start_o(perm_start_o), .perm_rounds_o(perm_rounds_o),
        .perm_state_o(perm_state_o), .perm_state_i(perm_state_i), .perm_done_i(perm_done_i),
        .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o)
    );

    always #5 clock_i = ~clock_i;

    localparam logic [63:0]  IV  = 64'h80400c0600000000;
    localparam logic [127:0] KEY = 128'h8A55114D1CB6A9A2BE263D4D7AECAAFF;
    localparam logic [127:0] NON = 128'h4ed0ec0b98c529b7c8cddf37bcd0284a;
    localparam logic [63:0]  AD  = 64'h4153434f4e2d4144;

    typedef struct {
        bit flip;
        int stall;
        int dmin;
        int dmax;
        bit stray;
        bit bstart;
        int abort;
        bit exp_ok;
    } vec_t;

    vec_t        tv[6];
    logic [63:0] pt[4];
    logic [63:0] g_ct[4];
    logic [127:0] g_tag;
    int          exp_r[6];

    int n_chk = 0;
    int n_fail = 0;

    int          dmin = 1;
    int          dmax = 1;
    bit          stray_req = 1'b0;
    int          stab_err = 0;
    int          done_cnt = 0;
    bit          tag_seen = 1'b0;
    logic [63:0] plain_q[$];
    int          rnd_log[$];

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_p(input logic [319:0] s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        for (int i = 12 - r; i < 12; i++) begin
            x2 ^= 64'(240 - 15 * i);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= rr(x0, 19) ^ rr(x0, 28);
            x1 ^= rr(x1, 61) ^ rr(x1, 39);
            x2 ^= rr(x2, 1)  ^ rr(x2, 6);
            x3 ^= rr(x3, 10) ^ rr(x3, 17);
            x4 ^= rr(x4, 7)  ^ rr(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    task automatic golden();
        logic [319:0] s;
        s = ascon_p({IV, KEY, NON}, 12);
        s[127:0] ^= KEY;
        s[319:256] ^= AD;
        s = ascon_p(s, 6);
        s[0] = ~s[0];
        for (int i = 0; i < 4; i++) begin
            g_ct[i] = s[319:256] ^ pt[i];
            s[319:256] = g_ct[i];
            if (i < 3) s = ascon_p(s, 6);
        end
        s ^= {64'h8000000000000000, KEY, 128'd0};
        s = ascon_p(s, 12);
        g_tag = s[127:0] ^ KEY;
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic zero_chk(input string pfx);
        chk({pfx, "_state"}, perm_state_o, '0);
        chk({pfx, "_ctrl"}, 320'({plain_o, ad_ready_o, cipher_ready_o, plain_valid_o,
                                  perm_start_o, perm_rounds_o, busy_o, done_o, tag_ok_o}), '0);
    endtask

    // Permutation responder: captures the request, checks the state is held, replies after a delay.
    initial begin
        logic [319:0] cap;
        int           rnd;
        int           left;
        bit           pend;
        pend = 1'b0; cap = '0; rnd = 0; left = 0;
        forever begin
            @(posedge clock_i);
            #1;
            perm_done_i = 1'b0;
            if (!resetb_i) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (perm_state_o !== cap) stab_err++;
                    if (left <= 1) begin
                        perm_state_i = ascon_p(cap, rnd);
                        perm_done_i  = 1'b1;
                        pend = 1'b0;
                    end else begin
                        left--;
                    end
                end else if (stray_req) begin
                    perm_state_i = {5{64'hdeadbeefcafef00d}};
                    perm_done_i  = 1'b1;
                    stray_req    = 1'b0;
                end
                if (perm_start_o) begin
                    cap  = perm_state_o;
                    rnd  = int'(perm_rounds_o);
                    rnd_log.push_back(rnd);
                    pend = 1'b1;
                    left = $urandom_range(dmax, dmin);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock_i);
            #1;
            if (plain_valid_o) plain_q.push_back(plain_o);
            if (done_o) begin
                done_cnt++;
                tag_seen = tag_ok_o;
            end
        end
    end

    task automatic wait_ready(input bit is_ct, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        while (!(is_ct ? cipher_ready_o : ad_ready_o)) begin
            tick();
            n++;
            if (n > 2000) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_blk(input bit is_ct, input logic [63:0] d, input int stall,
                            input bit stray, input bit bstart, output bit ok);
        ok = 1'b1;
        if (stall > 0) begin
            wait_ready(is_ct, ok);
            if (!ok) return;
            for (int i = 0; i < stall; i++) begin
                if (i == 0 && stray && !is_ct) stray_req = 1'b1;
                if (i == 1 && bstart) begin
                    start_i = 1'b1;
                    key_i   = ~KEY;
                end
                tick();
                start_i = 1'b0;
                key_i   = KEY;
            end
        end
        if (is_ct) begin cipher_i = d; cipher_valid_i = 1'b1; end
        else       begin ad_i = d;     ad_valid_i = 1'b1;     end
        wait_ready(is_ct, ok);
        if (ok) tick();
        cipher_valid_i = 1'b0;
        ad_valid_i     = 1'b0;
    endtask

    task automatic run_msg(input vec_t v, input bit first);
        bit ok;
        int n;
        dmin = v.dmin;
        dmax = v.dmax;
        plain_q.delete();
        rnd_log.delete();
        done_cnt = 0;
        stab_err = 0;
        key_i   = KEY;
        nonce_i = NON;
        tag_i   = g_tag ^ {127'd0, v.flip};
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        if (first) begin
            n = 0;
            while (!perm_start_o && n < 100) begin tick(); n++; end
            if (!perm_start_o) begin tmo("init_start"); return; end
            chk("init_state", perm_state_o, {IV, KEY, NON});
            chk("init_rounds", 320'(perm_rounds_o), 320'd12);
        end
        send_blk(1'b0, AD, v.stall, v.stray, v.bstart, ok);
        if (!ok) begin tmo("ad_ready"); return; end
        for (int i = 0; i < 4; i++) begin
            send_blk(1'b1, g_ct[i], v.stall, 1'b0, 1'b0, ok);
            if (!ok) begin tmo("ct_ready"); return; end
            if (v.abort == i) begin
                repeat (2) tick();
                #2 resetb_i = 1'b0;
                #1 zero_chk("abort");
                tick(); tick();
                resetb_i = 1'b1;
                tick(); tick();
                return;
            end
        end
        n = 0;
        while (done_cnt == 0 && n < 2000) begin tick(); n++; end
        if (done_cnt == 0) begin tmo("done"); return; end
        tick(); tick();
        chk("plain_count", 320'(plain_q.size()), 320'd4);
        for (int i = 0; i < 4 && i < plain_q.size(); i++) chk("plain", 320'(plain_q[i]), 320'(pt[i]));
        chk("tag_ok", 320'(tag_seen), 320'(v.exp_ok));
        chk("tag_ok_hold", 320'(tag_ok_o), 320'(v.exp_ok));
        chk("done_count", 320'(done_cnt), 320'd1);
        chk("perm_count", 320'(rnd_log.size()), 320'd6);
        for (int i = 0; i < 6 && i < rnd_log.size(); i++) chk("perm_rounds", 320'(rnd_log[i]), 320'(exp_r[i]));
        chk("perm_stable", 320'(stab_err), 320'd0);
        chk("idle_busy", 320'(busy_o), 320'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pt[0] = 64'h0011223344556677; pt[1] = 64'h8899aabbccddeeff;
        pt[2] = 64'h0123456789abcdef; pt[3] = 64'hfedcba9876543210;
        exp_r = '{12, 6, 6, 6, 6, 12};
        //            flip stall dmin dmax stray bstart abort exp_ok
        tv[0] = '{1'b0, 0, 1,  1,  1'b0, 1'b0, -1, 1'b1};
        tv[1] = '{1'b1, 0, 1,  1,  1'b0, 1'b0, -1, 1'b0};
        tv[2] = '{1'b0, 5, 3,  20, 1'b0, 1'b0, -1, 1'b1};
        tv[3] = '{1'b0, 0, 10, 10, 1'b0, 1'b0, 1,  1'b1};
        tv[4] = '{1'b0, 0, 2,  4,  1'b0, 1'b0, -1, 1'b1};
        tv[5] = '{1'b0, 3, 1,  5,  1'b1, 1'b1, -1, 1'b1};
        golden();

        resetb_i = 1'b0;
        repeat (3) tick();
        zero_chk("reset");
        resetb_i = 1'b1;
        tick(); tick();
        zero_chk("post_reset");

        for (int i = 0; i < 6; i++) begin
            run_msg(tv[i], i == 0);
            repeat (3) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
